// File: rtl/bus_sel_arb_intc_pkg.sv
// Shared definitions for the fd-to-FIFO bus-select arbitrating interconnect.
// Holds the arbiter state encoding, the default port count and the
// slice-index helpers for the flattened PORT_NUM*PORT_NUM buses.
// Optional feature macro used elsewhere: BUS_SEL_HOLD_TIMEOUT_EN.
package bus_sel_arb_intc_pkg;

  typedef enum logic {
    BUS_SEL_IDLE  = 1'b0,
    BUS_SEL_GRANT = 1'b1
  } arb_state_e;

  localparam int BUS_SEL_PORT_NUM_DEF = 4;

  // LSB of slice i in a flattened bus of n-bit slices (fd_x or fifo_y).
  function automatic int slice_lsb(input int i, input int n);
    return i * n;
  endfunction

endpackage

// File: rtl/bus_sel_rr_arb.sv
// One round-robin arbiter with grant lock for a single FIFO.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req         one bit per fd requesting this FIFO
//   gnt_q       registered one-hot (or zero) owner
//   busy_q      registered, high whenever gnt_q is non-zero
// With BUS_SEL_HOLD_TIMEOUT_EN defined, an owner is forced off after
// MAX_HOLD cycles if anyone else is waiting.
module bus_sel_rr_arb
  import bus_sel_arb_intc_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_q,
  output logic         busy_q
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("bus_sel_rr_arb: N must be 2..16");
  end
  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("bus_sel_rr_arb: CNT_W too narrow for MAX_HOLD");
  end

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_d;
  logic          busy_d;
  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] win_nxt;

  // First requester at or above ptr_q, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    win_nxt = (int'(win) == N - 1) ? '0 : win + PW'(1);
  end

`ifdef BUS_SEL_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             others;
  assign others = |(req & ~gnt_q);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      BUS_SEL_IDLE: begin
        if (found) begin
          state_d = BUS_SEL_GRANT;
          gnt_d   = N'(1) << win;
          busy_d  = 1'b1;
          ptr_d   = win_nxt;
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS_SEL_GRANT: begin
        // Owner dropped: release, always through one idle cycle.
        if (!(|(req & gnt_q))) begin
          state_d = BUS_SEL_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD - 1) && others) begin
          state_d = BUS_SEL_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = BUS_SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUS_SEL_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: rtl/bus_sel_arb_intc.sv
// Arbitrating bus-select interconnect between the fd array and FIFO array.
// fd_x bit y requests fifo_y; each FIFO has its own round-robin arbiter
// with grant lock, so each fifo_y slice is one-hot or zero.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   fd_bus_sel    requests, slice x = fd_x, bit y = fifo_y
//   fifo_bus_sel  grants, slice y = fifo_y, bit x = fd_x owns it
//   fd_grant      same grants in fd order (slice x, bit y)
//   fifo_busy     bit y high when fifo_y has an owner
// Optional macro: BUS_SEL_HOLD_TIMEOUT_EN (bounded hold of MAX_HOLD cycles).
// All outputs are flop outputs, only re-wired here.
module bus_sel_arb_intc
  import bus_sel_arb_intc_pkg::*;
#(
  parameter int PORT_NUM = BUS_SEL_PORT_NUM_DEF,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORT_NUM*PORT_NUM-1:0] fd_bus_sel,
  output logic [PORT_NUM*PORT_NUM-1:0] fifo_bus_sel,
  output logic [PORT_NUM*PORT_NUM-1:0] fd_grant,
  output logic [PORT_NUM-1:0]          fifo_busy
);
  logic [PORT_NUM-1:0][PORT_NUM-1:0] req;  // [fifo][fd]
  logic [PORT_NUM-1:0][PORT_NUM-1:0] gnt;  // [fifo][fd]

  for (genvar y = 0; y < PORT_NUM; y++) begin : g_fifo
    for (genvar x = 0; x < PORT_NUM; x++) begin : g_fd
      assign req[y][x] = fd_bus_sel[slice_lsb(x, PORT_NUM) + y];
      assign fd_grant[slice_lsb(x, PORT_NUM) + y] = gnt[y][x];
    end

    bus_sel_rr_arb #(
      .N        (PORT_NUM),
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
    ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req[y]),
      .gnt_q  (gnt[y]),
      .busy_q (fifo_busy[y])
    );

    assign fifo_bus_sel[slice_lsb(y, PORT_NUM) +: PORT_NUM] = gnt[y];
  end

endmodule

// File: tb/tb_bus_sel_arb_intc.sv
module tb_bus_sel_arb_intc;
  localparam int N = 4;
  localparam int W = N * N;
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
  localparam int MH = 8;
`else
  localparam int MH = 64;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] fd_bus_sel = '1;
  logic [W-1:0] fifo_bus_sel, fd_grant;
  logic [N-1:0] fifo_busy;

  bus_sel_arb_intc #(.PORT_NUM(N), .MAX_HOLD(MH), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .fd_bus_sel(fd_bus_sel),
    .fifo_bus_sel(fifo_bus_sel), .fd_grant(fd_grant), .fifo_busy(fifo_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] fifo;
    logic [W-1:0] fdg;
    logic [N-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: each FIFO tracks an owner index (-1 = free), a next-search
  // pointer and a hold length.
  int owner[N];
  int ptr[N];
  int hold[N];

  function automatic bit rq(input logic [W-1:0] v, input int x, input int y);
    return v[x*N + y];
  endfunction

  task automatic model_step();
    exp_t e;
    bit   other;
    e = '0;
    for (int y = 0; y < N; y++) begin
      if (!rst_n) begin
        owner[y] = -1; ptr[y] = 0; hold[y] = 0;
      end else if (owner[y] < 0) begin
        for (int k = 0; k < N; k++) begin
          int x;
          x = (ptr[y] + k) % N;
          if (owner[y] < 0 && rq(fd_bus_sel, x, y)) begin
            owner[y] = x; ptr[y] = (x + 1) % N; hold[y] = 0;
          end
        end
      end else if (!rq(fd_bus_sel, owner[y], y)) begin
        owner[y] = -1;
      end else begin
`ifdef BUS_SEL_HOLD_TIMEOUT_EN
        other = 1'b0;
        for (int x = 0; x < N; x++)
          if (x != owner[y] && rq(fd_bus_sel, x, y)) other = 1'b1;
        if (hold[y] == MH - 1 && other) owner[y] = -1;
        else if (hold[y] < MH) hold[y]++;
`else
        other = 1'b0;
`endif
      end
      if (owner[y] >= 0) begin
        e.fifo[y*N + owner[y]] = 1'b1;
        e.fdg[owner[y]*N + y]  = 1'b1;
        e.busy[y]              = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clk) model_step();

  // Monitor: one expected entry per clock, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (fifo_bus_sel !== e.fifo) begin
        errors++;
        $display("FAIL fifo_bus_sel @%0t: got %h want %h", $time, fifo_bus_sel, e.fifo);
      end
      checks++;
      if (fd_grant !== e.fdg) begin
        errors++;
        $display("FAIL fd_grant @%0t: got %h want %h", $time, fd_grant, e.fdg);
      end
      checks++;
      if (fifo_busy !== e.busy) begin
        errors++;
        $display("FAIL fifo_busy @%0t: got %b want %b", $time, fifo_busy, e.busy);
      end
    end
  end

  task automatic cyc(input logic [W-1:0] v);
    @(posedge clk);
    #1 fd_bus_sel = v;
  endtask

  initial begin
    logic [W-1:0] v;
    // Reset held with every request set, then released.
    repeat (3) cyc('1);
    rst_n = 1'b1;
    repeat (4) cyc('1);
    repeat (3) cyc('0);

    // Single request: fd_2 -> fifo_1.
    repeat (4) cyc(W'(1) << (2*N + 1));
    repeat (2) cyc('0);

    // Round robin on fifo_0: every fd requests, an owner drops for one
    // cycle as soon as its grant is visible.
    for (int c = 0; c < 24; c++) begin
      v = '0;
      for (int x = 0; x < N; x++)
        if (owner[0] != x) v[x*N] = 1'b1;
      cyc(v);
    end
    repeat (2) cyc('0);

    // Lock: fd_1 owns fifo_3, fd_0 keeps asking.
    repeat (2) cyc(W'(1) << (1*N + 3));
    repeat (100) cyc((W'(1) << (1*N + 3)) | (W'(1) << 3));
    repeat (5) cyc(W'(1) << 3);
    repeat (2) cyc('0);

    // Randomised traffic: bits flip with probability 1/8 per cycle.
    v = '0;
    for (int c = 0; c < 2000; c++) begin
      v ^= W'($urandom & $urandom & $urandom);
      cyc(v);
    end

    // Async reset in the middle of live grants.
    repeat (6) cyc('1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    #1;
    checks++;
    if (fifo_bus_sel !== '0 || fd_grant !== '0 || fifo_busy !== '0) begin
      errors++;
      $display("FAIL async_rst: got fifo=%h fdg=%h busy=%b want all 0",
               fifo_bus_sel, fd_grant, fifo_busy);
    end
    repeat (3) cyc('1);
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      v ^= W'($urandom & $urandom);
      cyc(v);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
